// File: rtl/cq_axil_bridge.sv
// Bridges single-DW CQ memory requests that hit the register window onto AXI-Lite,
// returning read completions on CC; every other CQ beat passes through one register stage.
module cq_axil_bridge #(
    parameter int          AXIS_DATA_WIDTH = 512,
    parameter int          AXIS_KEEP_WIDTH = 64,
    parameter int          CQ_USER_WIDTH   = 183,
    parameter int          CC_USER_WIDTH   = 81,
    parameter int          AXIL_ADDR_WIDTH = 8,
    parameter logic [31:0] PROC_REQ_ID     = 32'h70747072,
    parameter int          WINDOW_ADDR_BIT = 23,
    parameter int          TIMEOUT_CYCLES  = 1024,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic [CQ_USER_WIDTH-1:0]   s_axis_tuser,
    output logic                       s_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                       m0_axis_tvalid,
    output logic [AXIS_KEEP_WIDTH-1:0] m0_axis_tkeep,
    output logic                       m0_axis_tlast,
    output logic [CQ_USER_WIDTH-1:0]   m0_axis_tuser,
    input  logic                       m0_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [CC_USER_WIDTH-1:0]   m_axis_tuser,
    input  logic                       m_axis_tready,

    output logic [AXIL_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [31:0]                m_axi_wdata,
    output logic [3:0]                 m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [31:0]                m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,

    output logic [CNT_WIDTH-1:0]       stat_wr_count,
    output logic [CNT_WIDTH-1:0]       stat_rd_count,
    output logic [CNT_WIDTH-1:0]       stat_err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_CA = 3'b100;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, CPL} state_t;

    state_t state_reg, state_next;

    logic                       in_pkt_reg;
    logic                       m0_tvalid_reg;
    logic [AXIS_DATA_WIDTH-1:0] m0_tdata_reg;
    logic [AXIS_KEEP_WIDTH-1:0] m0_tkeep_reg;
    logic                       m0_tlast_reg;
    logic [CQ_USER_WIDTH-1:0]   m0_tuser_reg;

    logic [AXIL_ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]                wdata_reg;
    logic [3:0]                 wstrb_reg;
    logic [15:0]                req_id_reg;
    logic [7:0]                 tag_reg;
    logic [2:0]                 tc_reg, attr_reg;
    logic [6:0]                 lower_addr_reg;

    logic awvalid_reg, awvalid_next;
    logic wvalid_reg, wvalid_next;
    logic bready_reg, bready_next;
    logic arvalid_reg, arvalid_next;
    logic rready_reg, rready_next;
    logic cc_valid_reg, cc_valid_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [2:0]  status_reg, status_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic wr_inc, rd_inc, err_inc;

    logic [CNT_WIDTH-1:0] wr_cnt_reg, rd_cnt_reg, err_cnt_reg;

    logic s_accept, win_cand, wr_hit, rd_hit, timed_out;

    // Decode only on the first beat of a packet; continuation beats are opaque payload.
    assign s_axis_tready = (state_reg == IDLE) && (!m0_tvalid_reg || m0_axis_tready);
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    assign win_cand      = !in_pkt_reg && s_axis_tdata[WINDOW_ADDR_BIT] &&
                           (s_axis_tdata[74:64] == 11'd1) && s_axis_tlast;
    assign rd_hit        = win_cand && (s_axis_tdata[78:75] == 4'b0000);
    assign wr_hit        = win_cand && (s_axis_tdata[78:75] == 4'b0001) &&
                           (s_axis_tdata[159:128] == PROC_REQ_ID);
    assign timed_out     = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_reg    <= 1'b0;
            m0_tvalid_reg <= 1'b0;
            m0_tdata_reg  <= '0;
            m0_tkeep_reg  <= '0;
            m0_tlast_reg  <= 1'b0;
            m0_tuser_reg  <= '0;
        end else begin
            if (s_accept)
                in_pkt_reg <= !s_axis_tlast;
            if (s_accept && !(wr_hit || rd_hit)) begin
                m0_tvalid_reg <= 1'b1;
                m0_tdata_reg  <= s_axis_tdata;
                m0_tkeep_reg  <= s_axis_tkeep;
                m0_tlast_reg  <= s_axis_tlast;
                m0_tuser_reg  <= s_axis_tuser;
            end else if (m0_axis_tready) begin
                m0_tvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            req_id_reg     <= '0;
            tag_reg        <= '0;
            tc_reg         <= '0;
            attr_reg       <= '0;
            lower_addr_reg <= '0;
        end else if (s_accept && (wr_hit || rd_hit)) begin
            addr_reg       <= {s_axis_tdata[AXIL_ADDR_WIDTH-1:2], 2'b00};
            wdata_reg      <= s_axis_tdata[191:160];
            wstrb_reg      <= s_axis_tuser[3:0];
            req_id_reg     <= s_axis_tdata[95:80];
            tag_reg        <= s_axis_tdata[103:96];
            tc_reg         <= s_axis_tdata[123:121];
            attr_reg       <= s_axis_tdata[126:124];
            lower_addr_reg <= {s_axis_tdata[6:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            bready_reg   <= 1'b0;
            arvalid_reg  <= 1'b0;
            rready_reg   <= 1'b0;
            cc_valid_reg <= 1'b0;
            rdata_reg    <= '0;
            status_reg   <= '0;
            timer_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            awvalid_reg  <= awvalid_next;
            wvalid_reg   <= wvalid_next;
            bready_reg   <= bready_next;
            arvalid_reg  <= arvalid_next;
            rready_reg   <= rready_next;
            cc_valid_reg <= cc_valid_next;
            rdata_reg    <= rdata_next;
            status_reg   <= status_next;
            timer_reg    <= timer_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        awvalid_next  = awvalid_reg;
        wvalid_next   = wvalid_reg;
        bready_next   = bready_reg;
        arvalid_next  = arvalid_reg;
        rready_next   = rready_reg;
        cc_valid_next = cc_valid_reg;
        rdata_next    = rdata_reg;
        status_next   = status_reg;
        timer_next    = timer_reg;
        wr_inc        = 1'b0;
        rd_inc        = 1'b0;
        err_inc       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_accept && wr_hit) begin
                    state_next   = WR;
                    awvalid_next = 1'b1;
                    wvalid_next  = 1'b1;
                end else if (s_accept && rd_hit) begin
                    state_next   = RD_A;
                    arvalid_next = 1'b1;
                end
            end
            WR: begin
                awvalid_next = awvalid_reg && !m_axi_awready;
                wvalid_next  = wvalid_reg && !m_axi_wready;
                if (!awvalid_next && !wvalid_next) begin
                    state_next  = WR_B;
                    bready_next = 1'b1;
                    timer_next  = '0;
                end
            end
            WR_B: begin
                if (m_axi_bvalid && bready_reg) begin
                    state_next  = IDLE;
                    bready_next = 1'b0;
                    wr_inc      = 1'b1;
                    err_inc     = (m_axi_bresp != 2'b00);
                end else if (timed_out) begin
                    state_next  = IDLE;
                    bready_next = 1'b0;
                    err_inc     = 1'b1;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            RD_A: begin
                if (m_axi_arready) begin
                    state_next   = RD_R;
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    timer_next   = '0;
                end
            end
            RD_R: begin
                if (m_axi_rvalid && rready_reg) begin
                    state_next    = CPL;
                    rready_next   = 1'b0;
                    cc_valid_next = 1'b1;
                    rdata_next    = m_axi_rdata;
                    status_next   = (m_axi_rresp == 2'b00) ? CPL_SC : CPL_CA;
                    err_inc       = (m_axi_rresp != 2'b00);
                end else if (timed_out) begin
                    // Abort: the requester still gets a completion so it never hangs.
                    state_next    = CPL;
                    rready_next   = 1'b0;
                    cc_valid_next = 1'b1;
                    rdata_next    = 32'hFFFF_FFFF;
                    status_next   = CPL_CA;
                    err_inc       = 1'b1;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            CPL: begin
                if (m_axis_tready) begin
                    state_next    = IDLE;
                    cc_valid_next = 1'b0;
                    rd_inc        = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (wr_inc && (wr_cnt_reg != '1))
                wr_cnt_reg <= wr_cnt_reg + CNT_WIDTH'(1);
            if (rd_inc && (rd_cnt_reg != '1))
                rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
            if (err_inc && (err_cnt_reg != '1))
                err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
        end
    end

    logic [31:0] cc_dw0, cc_dw1, cc_dw2;
    assign cc_dw0 = {3'b0, 13'd4, 6'b0, 2'b00, 1'b0, lower_addr_reg};
    assign cc_dw1 = {req_id_reg, 1'b0, 1'b0, status_reg, 11'd1};
    assign cc_dw2 = {1'b0, attr_reg, tc_reg, 1'b0, 16'h0, tag_reg};

    // CC fields are gated so the bus reads all-zero whenever no completion is offered.
    assign m_axis_tvalid = cc_valid_reg;
    assign m_axis_tdata  = cc_valid_reg ?
                           {{(AXIS_DATA_WIDTH-128){1'b0}}, rdata_reg, cc_dw2, cc_dw1, cc_dw0} : '0;
    assign m_axis_tkeep  = cc_valid_reg ? {{(AXIS_KEEP_WIDTH-4){1'b0}}, 4'hF} : '0;
    assign m_axis_tlast  = cc_valid_reg;
    assign m_axis_tuser  = '0;

    assign m0_axis_tvalid = m0_tvalid_reg;
    assign m0_axis_tdata  = m0_tdata_reg;
    assign m0_axis_tkeep  = m0_tkeep_reg;
    assign m0_axis_tlast  = m0_tlast_reg;
    assign m0_axis_tuser  = m0_tuser_reg;

    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

    assign stat_wr_count  = wr_cnt_reg;
    assign stat_rd_count  = rd_cnt_reg;
    assign stat_err_count = err_cnt_reg;

endmodule

// File: tb/tb_cq_axil_bridge.sv
// Randomized bench for cq_axil_bridge: a request-level model predicts m0 beats,
// AXI-Lite transactions, CC completions and status counters.
module tb_cq_axil_bridge;

    localparam int TO = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [511:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tlast = 1'b0;
    logic [182:0] s_axis_tuser = '0;
    logic         s_axis_tready;
    logic [511:0] m0_axis_tdata;
    logic         m0_axis_tvalid;
    logic [63:0]  m0_axis_tkeep;
    logic         m0_axis_tlast;
    logic [182:0] m0_axis_tuser;
    logic         m0_axis_tready = 1'b1;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [80:0]  m_axis_tuser;
    logic         m_axis_tready = 1'b0;
    logic [7:0]   m_axi_awaddr, m_axi_araddr;
    logic [2:0]   m_axi_awprot, m_axi_arprot;
    logic         m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
    logic         m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic [31:0]  m_axi_wdata;
    logic [3:0]   m_axi_wstrb;
    logic [1:0]   m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic         m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [31:0]  m_axi_rdata = '0;
    logic [15:0]  stat_wr_count, stat_rd_count, stat_err_count;

    cq_axil_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tkeep(m0_axis_tkeep),
        .m0_axis_tlast(m0_axis_tlast), .m0_axis_tuser(m0_axis_tuser), .m0_axis_tready(m0_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count), .stat_err_count(stat_err_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [511:0] d;
        logic [182:0] u;
        logic [63:0]  k;
        logic         l;
    } beat_t;

    beat_t exp_m0[$];
    int m_wr = 0, m_rd = 0, m_err = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, aw_hi = 0, w_hi = 0, rr_hi = 0;
    bit m0_rand = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            if (m0_axis_tvalid && m0_axis_tready) begin
                if (exp_m0.size() == 0) begin
                    chk("m0_extra_beat", 512'(1), 512'(0));
                end else begin
                    b = exp_m0.pop_front();
                    chk("m0_data", m0_axis_tdata, b.d);
                    chk("m0_user", 512'(m0_axis_tuser), 512'(b.u));
                    chk("m0_keep_last", 512'({m0_axis_tlast, m0_axis_tkeep}), 512'({b.l, b.k}));
                end
            end
            if (m_axi_awvalid && m_axi_awready) aw_hs++;
            if (m_axi_wvalid && m_axi_wready)   w_hs++;
            if (m_axi_arvalid && m_axi_arready) ar_hs++;
            if (m_axi_awvalid) aw_hi++;
            if (m_axi_wvalid)  w_hi++;
            if (m_axi_rready)  rr_hi++;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        m0_axis_tready = m0_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    function automatic beat_t rand_beat();
        beat_t b;
        logic [191:0] u;
        for (int i = 0; i < 16; i++) b.d[i*32 +: 32] = $urandom();
        for (int i = 0; i < 6; i++)  u[i*32 +: 32] = $urandom();
        b.u = u[182:0];
        b.k = {$urandom(), $urandom()};
        b.l = 1'b1;
        return b;
    endfunction

    function automatic beat_t make_req(input logic [3:0] typ, input logic [31:0] addr,
                                       input logic [10:0] dw, input logic [15:0] rid,
                                       input logic [7:0] tag, input logic [31:0] marker,
                                       input logic [31:0] wd, input logic [3:0] be);
        beat_t b = rand_beat();
        b.d[31:0]    = addr;
        b.d[74:64]   = dw;
        b.d[78:75]   = typ;
        b.d[95:80]   = rid;
        b.d[103:96]  = tag;
        b.d[159:128] = marker;
        b.d[191:160] = wd;
        b.u[3:0]     = be;
        b.l          = 1'b1;
        return b;
    endfunction

    // Completion model built from field positions with plain arithmetic.
    function automatic logic [511:0] cc_expect(input beat_t req, input logic [31:0] rd, input bit ca);
        logic [31:0] dw0, dw1, dw2;
        logic [511:0] r;
        dw0 = (32'd4 << 16) | ({25'd0, req.d[6:0]} & 32'h7C);
        dw1 = ({16'd0, req.d[95:80]} << 16) | (ca ? 32'h2000 : 32'h0) | 32'd1;
        dw2 = ({29'd0, req.d[126:124]} << 28) | ({29'd0, req.d[123:121]} << 25) | {24'd0, req.d[103:96]};
        r = '0;
        r[31:0] = dw0; r[63:32] = dw1; r[95:64] = dw2; r[127:96] = rd;
        return r;
    endfunction

    task automatic send_beat(input beat_t b);
        int n = 0;
        s_axis_tdata = b.d; s_axis_tuser = b.u; s_axis_tkeep = b.k; s_axis_tlast = b.l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 2000) begin @(negedge clk); n++; end
        if (!s_axis_tready) chk("s_ready_timeout", 512'(0), 512'(1));
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic aw_slave(input int dly, output logic [10:0] ap);
        int n = 0;
        ap = '0;
        while (!m_axi_awvalid && n < 100) begin @(posedge clk); #1; n++; end
        if (!m_axi_awvalid) begin chk("aw_wait", 512'(0), 512'(1)); return; end
        repeat (dly) begin @(posedge clk); #1; end
        m_axi_awready = 1'b1;
        @(negedge clk); ap = {m_axi_awprot, m_axi_awaddr};
        @(posedge clk); #1; m_axi_awready = 1'b0;
    endtask

    task automatic w_slave(input int dly, output logic [35:0] ws);
        int n = 0;
        ws = '0;
        while (!m_axi_wvalid && n < 100) begin @(posedge clk); #1; n++; end
        if (!m_axi_wvalid) begin chk("w_wait", 512'(0), 512'(1)); return; end
        repeat (dly) begin @(posedge clk); #1; end
        m_axi_wready = 1'b1;
        @(negedge clk); ws = {m_axi_wstrb, m_axi_wdata};
        @(posedge clk); #1; m_axi_wready = 1'b0;
    endtask

    task automatic ar_slave(input int dly, output logic [10:0] ap);
        int n = 0;
        ap = '0;
        while (!m_axi_arvalid && n < 100) begin @(posedge clk); #1; n++; end
        if (!m_axi_arvalid) begin chk("ar_wait", 512'(0), 512'(1)); return; end
        repeat (dly) begin @(posedge clk); #1; end
        m_axi_arready = 1'b1;
        @(negedge clk); ap = {m_axi_arprot, m_axi_araddr};
        @(posedge clk); #1; m_axi_arready = 1'b0;
    endtask

    task automatic b_slave(input int dly, input logic [1:0] resp);
        int n = 0;
        while (!m_axi_bready && n < 200) begin @(posedge clk); #1; n++; end
        if (!m_axi_bready) begin chk("b_wait", 512'(0), 512'(1)); return; end
        repeat (dly) begin @(posedge clk); #1; end
        m_axi_bvalid = 1'b1; m_axi_bresp = resp;
        @(posedge clk); #1; m_axi_bvalid = 1'b0;
    endtask

    task automatic r_slave(input int dly, input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        while (!m_axi_rready && n < 200) begin @(posedge clk); #1; n++; end
        if (!m_axi_rready) begin chk("r_wait", 512'(0), 512'(1)); return; end
        repeat (dly) begin @(posedge clk); #1; end
        m_axi_rvalid = 1'b1; m_axi_rdata = data; m_axi_rresp = resp;
        @(posedge clk); #1; m_axi_rvalid = 1'b0;
    endtask

    task automatic cc_sink(input int hold, output logic [511:0] d, output logic [145:0] side);
        int n = 0;
        logic [511:0] d0;
        bit bad = 1'b0;
        d = '0; side = '0;
        while (!m_axis_tvalid && n < 1500) begin @(posedge clk); #1; n++; end
        if (!m_axis_tvalid) begin chk("cc_wait", 512'(0), 512'(1)); return; end
        d0 = m_axis_tdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (m_axis_tdata !== d0 || !m_axis_tvalid || s_axis_tready) bad = 1'b1;
        end
        if (hold > 0) chk("cc_hold_stable", 512'(bad), 512'(0));
        m_axis_tready = 1'b1;
        @(negedge clk);
        d = m_axis_tdata; side = {m_axis_tlast, m_axis_tuser, m_axis_tkeep};
        @(posedge clk); #1; m_axis_tready = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        chk(tag, 512'({stat_wr_count, stat_rd_count, stat_err_count}),
            512'({16'(m_wr), 16'(m_rd), 16'(m_err)}));
    endtask

    task automatic do_write(input beat_t req, input int awd, input int wd, input int bd,
                            input logic [1:0] resp);
        logic [10:0] ap;
        logic [35:0] ws;
        int aw0 = aw_hs, w0 = w_hs, ar0 = ar_hs;
        fork
            send_beat(req);
            aw_slave(awd, ap);
            w_slave(wd, ws);
            b_slave(bd, resp);
        join
        m_wr++;
        if (resp != 2'b00) m_err++;
        chk("wr_awprot_addr", 512'(ap), 512'({3'b000, req.d[7:0] & 8'hFC}));
        chk("wr_strb_data", 512'(ws), 512'({req.u[3:0], req.d[191:160]}));
        chk("wr_handshakes", 512'({aw_hs - aw0, w_hs - w0, ar_hs - ar0}), 512'({32'd1, 32'd1, 32'd0}));
        check_stats("wr_stats");
    endtask

    task automatic do_read(input beat_t req, input int ard, input int rdd, input logic [31:0] rdat,
                           input logic [1:0] resp, input bit drop, input int hold,
                           output logic [511:0] got);
        logic [10:0] ap;
        logic [145:0] side;
        bit ca = drop || (resp != 2'b00);
        fork
            send_beat(req);
            ar_slave(ard, ap);
            if (!drop) r_slave(rdd, rdat, resp);
            cc_sink(hold, got, side);
        join
        m_rd++;
        if (ca) m_err++;
        chk("rd_arprot_addr", 512'(ap), 512'({3'b000, req.d[7:0] & 8'hFC}));
        chk("cc_tdata", got, cc_expect(req, drop ? 32'hFFFF_FFFF : rdat, ca));
        chk("cc_last_user_keep", 512'(side), 512'({1'b1, 81'd0, 64'h0F}));
        check_stats("rd_stats");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_m0.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        chk("m0_drain", 512'(exp_m0.size()), 512'(0));
    endtask

    initial begin
        beat_t req, b;
        logic [511:0] got;
        int aw0, w0, ar0, rr0, kind;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", 512'({m0_axis_tvalid, m_axis_tvalid, m_axi_awvalid, m_axi_wvalid,
                                m_axi_arvalid, m_axi_bready, m_axi_rready}), 512'(0));
        chk("rst_cc_data", m_axis_tdata, 512'(0));
        chk("rst_m0_data", m0_axis_tdata, 512'(0));
        check_stats("rst_stats");
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // Directed window write.
        req = make_req(4'b0001, 32'h0080_0010, 11'd1, 16'h0000, 8'h00, 32'h7074_7072, 32'hCAFE_F00D, 4'hF);
        do_write(req, 0, 0, 1, 2'b00);
        chk("wr_stat_plan", 512'(stat_wr_count), 512'(1));

        // Directed read with OKAY response.
        req = make_req(4'b0000, 32'h0080_0024, 11'd1, 16'h0100, 8'h5A, 32'h0, 32'h0, 4'hF);
        req.d[126:121] = 6'b0;
        do_read(req, 0, 1, 32'h1234_5678, 2'b00, 1'b0, 0, got);
        chk("cc_dw1_plan", 512'(got[63:32]), 512'(32'h0100_0001));
        chk("cc_tag_plan", 512'(got[71:64]), 512'(8'h5A));
        chk("cc_dw3_plan", 512'(got[127:96]), 512'(32'h1234_5678));
        chk("cc_lowaddr_plan", 512'(got[6:0]), 512'(7'h24));

        // SLVERR read, then a read that never gets an R response.
        req = make_req(4'b0000, 32'h0080_0008, 11'd1, 16'h0203, 8'h11, 32'h0, 32'h0, 4'hF);
        do_read(req, 2, 0, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, got);
        chk("cc_status_err", 512'(got[45:43]), 512'(3'b100));
        chk("err_after_slverr", 512'(stat_err_count), 512'(1));
        rr0 = rr_hi;
        req = make_req(4'b0000, 32'h0080_00FC, 11'd1, 16'h0405, 8'h22, 32'h0, 32'h0, 4'hF);
        do_read(req, 0, 0, 32'h0, 2'b00, 1'b1, 0, got);
        chk("timeout_data", 512'(got[127:96]), 512'(32'hFFFF_FFFF));
        chk("timeout_err", 512'(stat_err_count), 512'(2));
        chk("timeout_rready_cycles", 512'(rr_hi - rr0), 512'(TO));

        // Three-beat packet whose later beats look like window writes.
        aw0 = aw_hs; ar0 = ar_hs;
        for (int i = 0; i < 3; i++) begin
            b = make_req(4'b0001, 32'h0080_0040, 11'd1, 16'h0, 8'h0, 32'h7074_7072, $urandom(), 4'hF);
            b.l = (i == 2);
            if (i == 0) b.d[23] = 1'b0;
            exp_m0.push_back(b);
            send_beat(b);
        end
        wait_drain();
        chk("pkt_no_axi", 512'({aw_hs - aw0, ar_hs - ar0}), 512'(0));

        // Delayed awready with immediate wready; CC held off for 10 cycles.
        aw0 = aw_hi; w0 = w_hi;
        req = make_req(4'b0001, 32'h0080_0034, 11'd1, 16'h0, 8'h0, 32'h7074_7072, 32'h0BAD_CAFE, 4'h3);
        do_write(req, 4, 0, 0, 2'b00);
        chk("aw_valid_cycles", 512'(aw_hi - aw0), 512'(5));
        chk("w_valid_cycles", 512'(w_hi - w0), 512'(1));
        req = make_req(4'b0000, 32'h0080_0050, 11'd1, 16'hABCD, 8'h77, 32'h0, 32'h0, 4'hF);
        do_read(req, 1, 1, $urandom(), 2'b00, 1'b0, 10, got);

        // Randomized mix with back-pressure on m0.
        m0_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    b = rand_beat(); b.d[23] = 1'b0;
                    exp_m0.push_back(b); send_beat(b);
                end
                1: begin
                    int nb = $urandom_range(2, 4);
                    for (int j = 0; j < nb; j++) begin
                        b = rand_beat(); b.l = (j == nb - 1);
                        exp_m0.push_back(b); send_beat(b);
                    end
                end
                2: begin
                    req = make_req(4'b0001, {8'h0, 8'h80, 16'($urandom())}, 11'd1, 16'($urandom()),
                                   8'($urandom()), 32'h7074_7072, $urandom(), 4'($urandom()));
                    do_write(req, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                             2'($urandom_range(0, 3)));
                end
                3: begin
                    req = make_req(4'b0000, {8'h0, 8'h80, 16'($urandom())}, 11'd1, 16'($urandom()),
                                   8'($urandom()), $urandom(), $urandom(), 4'hF);
                    do_read(req, $urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
                            ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b00, 1'b0, $urandom_range(0, 3), got);
                end
                default: begin
                    int v = $urandom_range(0, 2);
                    b = make_req((v == 2) ? 4'b0010 : 4'b0001, 32'h0080_0010, (v == 0) ? 11'd2 : 11'd1,
                                 16'h0, 8'h0, (v == 1) ? 32'h7074_7073 : 32'h7074_7072, $urandom(), 4'hF);
                    exp_m0.push_back(b); send_beat(b);
                end
            endcase
        end
        wait_drain();
        m0_rand = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of waiting for R.
        req = make_req(4'b0000, 32'h0080_0030, 11'd1, 16'h1, 8'h1, 32'h0, 32'h0, 4'hF);
        begin
            logic [10:0] ap;
            fork
                send_beat(req);
                ar_slave(0, ap);
            join
        end
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_rready", 512'(m_axi_rready), 512'(1));
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_valids", 512'({m0_axis_tvalid, m_axis_tvalid, m_axi_awvalid, m_axi_wvalid,
                                    m_axi_arvalid, m_axi_bready, m_axi_rready}), 512'(0));
        m_wr = 0; m_rd = 0; m_err = 0;
        check_stats("rst_mid_stats");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // One-cycle passthrough latency after reset.
        b = rand_beat(); b.d[23] = 1'b0;
        exp_m0.push_back(b);
        s_axis_tdata = b.d; s_axis_tuser = b.u; s_axis_tkeep = b.k; s_axis_tlast = b.l;
        s_axis_tvalid = 1'b1;
        chk("lat_pre_valid", 512'(m0_axis_tvalid), 512'(0));
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        chk("lat_valid", 512'(m0_axis_tvalid), 512'(1));
        chk("lat_data", m0_axis_tdata, b.d);
        wait_drain();
        check_stats("final_stats");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
